mem_arb_ctrl: RTL

Two-port round-robin arbiter and access sequencer for the 4K x 8 memory (cen/rd/wr/add/din/dout interface).
- Shares the single memory port between requesters A and B.
- Issues one single-cycle strobe per access.
- Waits out the memory read latency, then returns read data to the owning requester.
- Sits between requesting engines and mem_dut, in the same clk domain.

---
 rtl/mem_arb_ctrl.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/mem_arb_ctrl.sv
// mem_arb_ctrl
//   Two-port round-robin arbiter and access sequencer for the 4K x 8 memory
//   (cen/rd/wr/add/din/dout interface). Requesters A and B share the single
//   memory port. Each access is one single-cycle strobe. Read data comes back
//   to the owning requester after the memory read latency.
//
// Parameters
//   RD_LAT  memory read latency in cycles (1..15)
//   AW      address width
//   DW      data width
//
// Ports
//   clk, rst                       clock (rising edge), async active-low reset
//   req_x/we_x/addr_x/wdata_x      requester x command (x = a, b), held until gnt_x
//   gnt_x                          one-cycle pulse when x's command is issued
//   rvalid_x/rdata_x               read return pulse; rdata_x is held until x's next read
//   cen/rd/wr/add/din/dout         memory interface
//   busy                           high while not idle
//   gnt_cnt_a/gnt_cnt_b            saturating grant counters
//
// Build option
//   MEM_ARB_STATS_EN  when defined, enables the grant counters; otherwise
//                     gnt_cnt_a/gnt_cnt_b are tied to zero.
module mem_arb_ctrl #(
   parameter int unsigned RD_LAT = 1,
   parameter int unsigned AW     = 12,
   parameter int unsigned DW     = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req_a,
   input  logic          we_a,
   input  logic [AW-1:0] addr_a,
   input  logic [DW-1:0] wdata_a,
   output logic          gnt_a,
   output logic          rvalid_a,
   output logic [DW-1:0] rdata_a,
   input  logic          req_b,
   input  logic          we_b,
   input  logic [AW-1:0] addr_b,
   input  logic [DW-1:0] wdata_b,
   output logic          gnt_b,
   output logic          rvalid_b,
   output logic [DW-1:0] rdata_b,
   output logic          cen,
   output logic          rd,
   output logic          wr,
   output logic [AW-1:0] add,
   output logic [DW-1:0] din,
   input  logic [DW-1:0] dout,
   output logic          busy,
   output logic [15:0]   gnt_cnt_a,
   output logic [15:0]   gnt_cnt_b
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;
   typedef enum logic {OWN_A, OWN_B} owner_e;

   localparam logic [3:0] LAT_INIT = 4'(RD_LAT - 1);

   state_e        state_q, state_d;
   owner_e        owner_q, owner_d;
   owner_e        last_q, last_d;
   logic          we_q, we_d;
   logic [3:0]    lat_q, lat_d;
   logic          cen_q, cen_d, rd_q, rd_d, wr_q, wr_d;
   logic [AW-1:0] add_q, add_d;
   logic [DW-1:0] din_q, din_d;
   logic          gnt_a_q, gnt_a_d, gnt_b_q, gnt_b_d;
   logic          rvalid_a_q, rvalid_a_d, rvalid_b_q, rvalid_b_d;
   logic [DW-1:0] rdata_a_q, rdata_a_d, rdata_b_q, rdata_b_d;
   logic          busy_q, busy_d;
   logic          pick_b;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         owner_q    <= OWN_A;
         last_q     <= OWN_B;
         we_q       <= 1'b0;
         lat_q      <= '0;
         cen_q      <= 1'b0;
         rd_q       <= 1'b0;
         wr_q       <= 1'b0;
         add_q      <= '0;
         din_q      <= '0;
         gnt_a_q    <= 1'b0;
         gnt_b_q    <= 1'b0;
         rvalid_a_q <= 1'b0;
         rvalid_b_q <= 1'b0;
         rdata_a_q  <= '0;
         rdata_b_q  <= '0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         last_q     <= last_d;
         we_q       <= we_d;
         lat_q      <= lat_d;
         cen_q      <= cen_d;
         rd_q       <= rd_d;
         wr_q       <= wr_d;
         add_q      <= add_d;
         din_q      <= din_d;
         gnt_a_q    <= gnt_a_d;
         gnt_b_q    <= gnt_b_d;
         rvalid_a_q <= rvalid_a_d;
         rvalid_b_q <= rvalid_b_d;
         rdata_a_q  <= rdata_a_d;
         rdata_b_q  <= rdata_b_d;
         busy_q     <= busy_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      last_d     = last_q;
      we_d       = we_q;
      lat_d      = lat_q;
      cen_d      = 1'b0;
      rd_d       = 1'b0;
      wr_d       = 1'b0;
      add_d      = '0;
      din_d      = '0;
      gnt_a_d    = 1'b0;
      gnt_b_d    = 1'b0;
      rvalid_a_d = 1'b0;
      rvalid_b_d = 1'b0;
      rdata_a_d  = rdata_a_q;
      rdata_b_d  = rdata_b_q;
      pick_b     = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (req_a || req_b) begin
               // B wins when alone, or on a tie when A owned the last grant.
               pick_b  = req_b && (!req_a || (last_q == OWN_A));
               owner_d = pick_b ? OWN_B : OWN_A;
               last_d  = owner_d;
               we_d    = pick_b ? we_b : we_a;
               // Issue-cycle outputs are registered here so they appear in ISSUE.
               cen_d   = 1'b1;
               wr_d    = we_d;
               rd_d    = ~we_d;
               add_d   = pick_b ? addr_b : addr_a;
               din_d   = we_d ? (pick_b ? wdata_b : wdata_a) : '0;
               gnt_a_d = ~pick_b;
               gnt_b_d = pick_b;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            if (we_q) begin
               state_d = IDLE;
            end else begin
               // Every read spends RD_LAT cycles in WAIT so dout is captured at
               // the edge ending T+RD_LAT and rvalid lands in T+RD_LAT+1 for any latency.
               state_d = WAIT;
               lat_d   = LAT_INIT;
            end
         end
         WAIT: begin
            if (lat_q == '0) begin
               state_d = DONE;
               if (owner_q == OWN_B) begin
                  rdata_b_d  = dout;
                  rvalid_b_d = 1'b1;
               end else begin
                  rdata_a_d  = dout;
                  rvalid_a_d = 1'b1;
               end
            end else begin
               lat_d = lat_q - 4'd1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   assign cen      = cen_q;
   assign rd       = rd_q;
   assign wr       = wr_q;
   assign add      = add_q;
   assign din      = din_q;
   assign gnt_a    = gnt_a_q;
   assign gnt_b    = gnt_b_q;
   assign rvalid_a = rvalid_a_q;
   assign rvalid_b = rvalid_b_q;
   assign rdata_a  = rdata_a_q;
   assign rdata_b  = rdata_b_q;
   assign busy     = busy_q;

`ifdef MEM_ARB_STATS_EN
   logic [15:0] cnt_a_q, cnt_b_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_a_q <= '0;
         cnt_b_q <= '0;
      end else begin
         if (gnt_a_q && (cnt_a_q != '1)) cnt_a_q <= cnt_a_q + 16'd1;
         if (gnt_b_q && (cnt_b_q != '1)) cnt_b_q <= cnt_b_q + 16'd1;
      end
   end

   assign gnt_cnt_a = cnt_a_q;
   assign gnt_cnt_b = cnt_b_q;
`else
   assign gnt_cnt_a = '0;
   assign gnt_cnt_b = '0;
`endif

endmodule
